// File: rtl/direction_input_ctrl_pkg.sv
// Shared direction encoding for the snake game core (input control, snake logic, food).
package direction_input_ctrl_pkg;

    typedef logic [3:0] dir_t;

    localparam dir_t DIR_UP    = 4'b1000;
    localparam dir_t DIR_DOWN  = 4'b0100;
    localparam dir_t DIR_LEFT  = 4'b0010;
    localparam dir_t DIR_RIGHT = 4'b0001;

    // 180-degree reversal of a one-hot direction; non-one-hot input yields zero.
    function automatic dir_t opposite(input dir_t d);
        case (d)
            DIR_UP:    return DIR_DOWN;
            DIR_DOWN:  return DIR_UP;
            DIR_LEFT:  return DIR_RIGHT;
            DIR_RIGHT: return DIR_LEFT;
            default:   return 4'b0000;
        endcase
    endfunction

    // Keep only the highest-priority strobe: up > down > left > right.
    function automatic dir_t prio_encode(input logic [3:0] strobes);
        if (strobes[3])      return DIR_UP;
        else if (strobes[2]) return DIR_DOWN;
        else if (strobes[1]) return DIR_LEFT;
        else if (strobes[0]) return DIR_RIGHT;
        else                 return 4'b0000;
    endfunction

endpackage

// File: rtl/direction_input_ctrl_key_debouncer.sv
// One push-button: 2-flop synchroniser, stability counter, debounced level and
// a registered one-cycle strobe on each released->pressed transition.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic             level_d1_reg;
    logic             press_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Bring the raw active-low button into the clock domain (idle level is released = 1).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
        end else begin
            sync1_reg <= key_n;
            sync2_reg <= sync1_reg;
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_reg <= 1'b1;
            cnt_reg   <= '0;
        end else if (sync2_reg == level_reg) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_reg <= sync2_reg;
            cnt_reg   <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // Registered press strobe from the debounced falling edge; releases are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_d1_reg <= 1'b1;
            press_reg    <= 1'b0;
        end else begin
            level_d1_reg <= level_reg;
            press_reg    <= level_d1_reg & ~level_reg;
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/direction_input_ctrl.sv
// Button-to-direction front end: four debounced keys, reversal/repeat rejection,
// a small pending-turn queue and one committed turn per game tick.
module direction_input_ctrl
    import direction_input_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int QUEUE_DEPTH     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_n,
    input  logic       tick,
    input  logic       enable,
    input  logic       clear,
    output logic [3:0] dir_out,
    output logic       dir_changed,
    output logic [2:0] queue_count,
    output logic       drop
);

    logic [3:0] press;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_key
            key_debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_key (
                .clk  (clk),
                .reset(reset),
                .key_n(key_n[gi]),
                .press(press[gi])
            );
        end
    endgenerate

    dir_t       queue_reg  [QUEUE_DEPTH];
    dir_t       queue_next [QUEUE_DEPTH];
    logic [2:0] count_reg, count_next;
    dir_t       dir_reg, dir_next;
    logic       drop_reg, drop_next;
    logic       chg_pending_reg;
    logic       dir_changed_reg;

    dir_t       sel;
    dir_t       ref_dir;
    logic       valid;
    logic       pop;
    logic       full;
    logic       push;
    int         after_pop;

    // Validate the winning press against the newest pending turn, then apply pop/push/clear.
    always_comb begin
        sel        = prio_encode(press);
        ref_dir    = dir_reg;
        queue_next = queue_reg;
        dir_next   = dir_reg;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (i + 1 == int'(count_reg)) ref_dir = queue_reg[i];
        end
        full  = (int'(count_reg) == QUEUE_DEPTH);
        pop   = tick && (count_reg != 3'd0);
        valid = enable && !clear && (sel != 4'b0000) &&
                (sel != ref_dir) && (sel != opposite(ref_dir));
        // A pop in the same cycle frees the slot a full queue would otherwise refuse.
        push  = valid && (!full || pop);

        after_pop = int'(count_reg);
        if (pop) begin
            dir_next = queue_reg[0];
            for (int i = 0; i < QUEUE_DEPTH - 1; i++) begin
                queue_next[i] = queue_reg[i + 1];
            end
            after_pop = after_pop - 1;
        end
        if (push) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (i == after_pop) queue_next[i] = sel;
            end
        end
        count_next = 3'(after_pop + (push ? 1 : 0));
        drop_next  = valid && full && !pop;

        if (clear) begin
            count_next = 3'd0;
            dir_next   = DIR_RIGHT;
            drop_next  = 1'b0;
        end
    end

    // Queue, committed direction and status pulses; dir_changed trails the dir_out update by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) queue_reg[i] <= DIR_RIGHT;
            count_reg       <= 3'd0;
            dir_reg         <= DIR_RIGHT;
            drop_reg        <= 1'b0;
            chg_pending_reg <= 1'b0;
            dir_changed_reg <= 1'b0;
        end else begin
            queue_reg       <= queue_next;
            count_reg       <= count_next;
            dir_reg         <= dir_next;
            drop_reg        <= drop_next;
            chg_pending_reg <= (dir_next != dir_reg);
            dir_changed_reg <= chg_pending_reg;
        end
    end

    assign dir_out     = dir_reg;
    assign dir_changed = dir_changed_reg;
    assign queue_count = count_reg;
    assign drop        = drop_reg;

endmodule

// File: tb/tb_direction_input_ctrl.sv
// Directed bench for direction_input_ctrl with a 4-cycle debounce and a 2-deep queue.
module tb_direction_input_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] key_n = 4'hF;
    logic       tick = 1'b0;
    logic       enable = 1'b1;
    logic       clear = 1'b0;
    logic [3:0] dir_out;
    logic       dir_changed;
    logic [2:0] queue_count;
    logic       drop;

    int checks = 0;
    int errors = 0;
    int drop_total = 0;
    int chg_total = 0;
    int onehot_bad = 0;

    direction_input_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3),
        .QUEUE_DEPTH    (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_n      (key_n),
        .tick       (tick),
        .enable     (enable),
        .clear      (clear),
        .dir_out    (dir_out),
        .dir_changed(dir_changed),
        .queue_count(queue_count),
        .drop       (drop)
    );

    always #5 clk = ~clk;

    // Pulse and invariant monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (drop) drop_total++;
        if (dir_changed) chg_total++;
        if (!reset && !$onehot(dir_out)) onehot_bad++;
    end

    typedef struct {
        int         key;      // -1: no press, only a tick
        bit         en;
        logic [3:0] exp_dir;
        int         exp_count;
        int         exp_drops;
        int         exp_chg;
        string      name;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic do_press(input int k);
        @(posedge clk); #1 key_n[k] = 1'b0;
        repeat (10) @(posedge clk);
        #1 key_n = 4'hF;
        repeat (12) @(posedge clk);
    endtask

    task automatic do_tick();
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic do_clear();
        @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        int d0, c0;

        tbl[0]  = '{1,  1'b1, 4'b0001, 0, 0, 0, "opposite_left"};
        tbl[1]  = '{0,  1'b1, 4'b0001, 0, 0, 0, "repeat_right"};
        tbl[2]  = '{3,  1'b1, 4'b0001, 1, 0, 0, "push_up"};
        tbl[3]  = '{1,  1'b1, 4'b0001, 2, 0, 0, "push_left"};
        tbl[4]  = '{2,  1'b1, 4'b0001, 2, 1, 0, "full_drop_down"};
        tbl[5]  = '{-1, 1'b1, 4'b1000, 1, 0, 1, "tick_up"};
        tbl[6]  = '{-1, 1'b1, 4'b0010, 0, 0, 1, "tick_left"};
        tbl[7]  = '{-1, 1'b1, 4'b0010, 0, 0, 0, "tick_empty"};
        tbl[8]  = '{0,  1'b1, 4'b0010, 0, 0, 0, "opposite_right"};
        tbl[9]  = '{3,  1'b0, 4'b0010, 0, 0, 0, "disabled_up"};
        tbl[10] = '{3,  1'b1, 4'b0010, 1, 0, 0, "push_up2"};
        tbl[11] = '{-1, 1'b1, 4'b1000, 0, 0, 1, "tick_up2"};

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dir", dir_out, 4'b0001);
        check("rst_count", queue_count, 0);
        check("rst_drop", drop, 0);
        check("rst_chg", dir_changed, 0);
        reset = 1'b0;

        // Idle with periodic ticks
        c0 = chg_total;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1 tick = (i % 8 == 0);
            @(negedge clk);
            check("idle_dir", dir_out, 4'b0001);
            check("idle_count", queue_count, 0);
        end
        tick = 1'b0;
        check("idle_chg", chg_total - c0, 0);

        // Short glitch on UP must not register
        @(posedge clk); #1 key_n[3] = 1'b0;
        repeat (3) @(posedge clk);
        #1 key_n = 4'hF;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("glitch_count", queue_count, 0);

        // Latency: push visible 8 cycles after the key edge
        @(posedge clk); #1 key_n[3] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); @(negedge clk);
            if (k == 7) check("lat_count_c7", queue_count, 0);
            if (k == 8) check("lat_count_c8", queue_count, 1);
        end
        key_n = 4'hF;
        repeat (12) @(posedge clk);
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
        @(negedge clk);
        check("lat_dir", dir_out, 4'b1000);
        check("lat_chg_c0", dir_changed, 0);
        @(negedge clk);
        check("lat_chg_c1", dir_changed, 1);
        @(negedge clk);
        check("lat_chg_c2", dir_changed, 0);

        // Back to reset state for the table
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        for (int t = 0; t < 12; t++) begin
            d0 = drop_total;
            c0 = chg_total;
            enable = tbl[t].en;
            if (tbl[t].key >= 0) do_press(tbl[t].key);
            else                 do_tick();
            @(negedge clk);
            check({tbl[t].name, "_dir"},   dir_out, tbl[t].exp_dir);
            check({tbl[t].name, "_count"}, queue_count, tbl[t].exp_count);
            check({tbl[t].name, "_drop"},  drop_total - d0, tbl[t].exp_drops);
            check({tbl[t].name, "_chg"},   chg_total - c0, tbl[t].exp_chg);
        end
        enable = 1'b1;

        // Full queue with a valid press landing on a tick
        do_clear();
        do_press(3);
        do_press(1);
        @(negedge clk);
        check("fq_count_pre", queue_count, 2);
        d0 = drop_total;
        @(posedge clk); #1 key_n[2] = 1'b0;
        repeat (7) @(posedge clk);
        #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
        @(negedge clk);
        check("fq_dir", dir_out, 4'b1000);
        check("fq_count", queue_count, 2);
        repeat (2) @(posedge clk);
        #1 key_n = 4'hF;
        repeat (12) @(posedge clk);
        check("fq_drop", drop_total - d0, 0);
        do_tick();
        @(negedge clk);
        check("fq_tick1_dir", dir_out, 4'b0010);
        do_tick();
        @(negedge clk);
        check("fq_tick2_dir", dir_out, 4'b0100);
        check("fq_tick2_count", queue_count, 0);

        // Clear with one pending turn
        do_press(1);
        @(negedge clk);
        check("clr_count_pre", queue_count, 1);
        c0 = chg_total;
        do_clear();
        @(negedge clk);
        check("clr_count", queue_count, 0);
        check("clr_dir", dir_out, 4'b0001);
        check("clr_chg", chg_total - c0, 1);

        // Async reset mid-queue and mid-debounce
        do_press(3);
        do_tick();
        do_press(1);
        @(negedge clk);
        check("ar_dir_pre", dir_out, 4'b1000);
        check("ar_count_pre", queue_count, 1);
        @(posedge clk); #1 key_n[2] = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("ar_dir", dir_out, 4'b0001);
        check("ar_count", queue_count, 0);
        check("ar_drop", drop, 0);
        check("ar_chg", dir_changed, 0);
        key_n = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("ar_after_count", queue_count, 0);
        check("ar_after_dir", dir_out, 4'b0001);

        check("onehot_violations", onehot_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/direction_input_ctrl.md
Name: direction_input_ctrl

Overview:
Upstream stage of the snake game core. Turns the four raw, active-low push-buttons into the registered one-hot direction bus that the snake logic samples (dirInControl).
- Synchronises and debounces each button.
- Rejects 180° reversals and repeats.
- Queues up to QUEUE_DEPTH pending turns so fast double-taps between game ticks are not lost.
- Commits one queued turn per game tick.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable samples before a key level is accepted (10 ms at 50 MHz)
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES
QUEUE_DEPTH, 2, pending-turn FIFO entries (legal values 1..4)

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-high reset
key_n  in  4  raw buttons, active low: [3]=up [2]=down [1]=left [0]=right
tick  in  1  one-cycle game-tick strobe (rate divider output)
enable  in  1  game running; when low, new presses are ignored
clear  in  1  synchronous flush: empty queue, dir_out to RIGHT
dir_out  out  4  committed one-hot direction, feeds snake logic dirInControl
dir_changed  out  1  one-cycle pulse the cycle after dir_out changes
queue_count  out  3  number of pending turns (0..QUEUE_DEPTH)
drop  out  1  one-cycle pulse when an accepted-valid press is lost to a full queue

Behaviour:
- Reset (async, high) values: dir_out=4'b0001 (RIGHT), dir_changed=0, queue_count=0, drop=0, all sync/debounce flops at "released", debounce counters 0.
- Synchroniser: 2 flops per key; downstream logic uses only synchronised levels.
- Debounce, per key:
  - The counter resets to 0 whenever the synchronised level equals the debounced level.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes the synchronised level and the counter returns to 0.
  - Glitches shorter than DEBOUNCE_CYCLES never propagate.
- Press event: debounced transition released→pressed, registered as a one-cycle strobe. Release transitions generate nothing.
- Multiple press strobes in the same cycle: only the highest priority is used (up > down > left > right); the others are discarded.
- Reference direction for validation: the tail queue entry if queue_count>0, else dir_out. Both are sampled before this cycle's push or pop.
- A press is valid iff enable=1, clear=0, its direction ≠ reference, and its direction ≠ opposite(reference).
- Push: valid press and queue not full → appended at tail.
- Valid press with queue full → not stored, drop=1 for one cycle.
  - Exception: if tick pops in the same cycle, the push succeeds and drop stays 0.
- Invalid presses are silently ignored; no drop pulse.
- Pop: tick=1 and queue_count>0 → head moves to dir_out on that edge; dir_changed=1 on the following cycle.
- tick with an empty queue: dir_out holds, no pulse.
- Simultaneous push and pop: both occur, queue_count unchanged. A push into an empty queue on a tick cycle is not committed until the next tick.
- clear has priority over everything except reset: queue emptied, dir_out=RIGHT, pending strobes discarded. dir_changed pulses next cycle only if dir_out actually changed.
- Latency: key edge to press strobe = 2 (sync) + DEBOUNCE_CYCLES + 1 cycles. Strobe to queue entry = 1 cycle. Queue head to dir_out = next tick.
- dir_out is always exactly one-hot; no reachable state violates this.
- Reset asserted mid-debounce or mid-queue: everything returns to reset values immediately, asynchronously.

Decomposition:
- Shared package:
  - direction localparams DIR_UP=4'b1000, DIR_DOWN=4'b0100, DIR_LEFT=4'b0010, DIR_RIGHT=4'b0001.
  - opposite() function (swap up/down, left/right).
  - Priority-encode function.
- The same constants are used by snake logic and food.
- Sub-module key_debouncer (synchroniser + counter + debounced level + press strobe), parameterised by DEBOUNCE_CYCLES/CNT_W, instantiated 4×.
- Queue and commit logic live in the top module.

Test Plan:
(All scenarios with DEBOUNCE_CYCLES=4, QUEUE_DEPTH=2.)
- Reset, then idle 20 cycles with ticks every 8 → dir_out=0001 throughout, queue_count=0, no dir_changed.
- Hold key_n[3] low 3 cycles, then release → no strobe, queue_count stays 0. Hold 10 cycles → queue_count=1 at cycle 8 after the edge; next tick → dir_out=1000, dir_changed one cycle later.
- From RIGHT, press left (opposite), then right (same) → both ignored, queue_count=0, drop=0.
- From RIGHT, press up, then left, then down before any tick → queue holds {UP,LEFT}, down is dropped with drop=1. Two ticks → dir_out 1000 then 0010.
- Queue full {UP,LEFT}: valid press DOWN strobe in the same cycle as tick → dir_out=1000, queue {LEFT,DOWN}, queue_count=2, drop=0.
- Queue count 1 then clear=1 → queue_count=0, dir_out=0001. Assert reset mid-debounce → all outputs return to reset values within the same cycle.
